// File: rtl/logic_sched_pkg.sv
// Shared types and constants for the logic-op scheduler, its arbiter and the logic unit.
package logic_sched_pkg;

  localparam int unsigned LU_OP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [LU_OP_W-1:0] NOTA = 3'd0;
  localparam logic [LU_OP_W-1:0] NOTB = 3'd1;
  localparam logic [LU_OP_W-1:0] AND  = 3'd2;
  localparam logic [LU_OP_W-1:0] OR   = 3'd3;
  localparam logic [LU_OP_W-1:0] XOR  = 3'd4;
  localparam logic [LU_OP_W-1:0] NAND = 3'd5;
  localparam logic [LU_OP_W-1:0] NOR  = 3'd6;
  localparam logic [LU_OP_W-1:0] XNOR = 3'd7;

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first asserted request at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] win_idx
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        found                = 1'b1;
        win[idx[PW-1:0]]     = 1'b1;
        win_idx              = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/logic_op_sched.sv
// Shares one logic unit between NREQ requesters: round-robin grant, start/finish
// handshake with timeout, registered one-hot done pulse back to the winner.
module logic_op_sched
  import logic_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*LU_OP_W-1:0] req_op,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        result,
  output logic                    err,
  output logic                    busy,
  output logic                    lu_start,
  output logic [WIDTH-1:0]        lu_a,
  output logic [WIDTH-1:0]        lu_b,
  output logic [LU_OP_W-1:0]      lu_op,
  input  logic                    lu_finish,
  input  logic [WIDTH-1:0]        lu_c
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, w_idx, win_idx;
  logic [NREQ-1:0] win;
  logic [CW-1:0]   cnt;
  logic            timed_out;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // The counter equals the number of WAIT cycles already spent; abort after TIMEOUT+1 of them.
  assign timed_out = (cnt == CW'(TIMEOUT));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (|req) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (lu_finish || timed_out) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Pulses and busy are registered from the next state so every output comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      w_idx    <= '0;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      result   <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      lu_start <= 1'b0;
      lu_a     <= '0;
      lu_b     <= '0;
      lu_op    <= '0;
    end else begin
      gnt      <= '0;
      done     <= '0;
      lu_start <= 1'b0;
      busy     <= (state_nx != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (|req) begin
            w_idx    <= win_idx;
            lu_a     <= req_a[win_idx*WIDTH +: WIDTH];
            lu_b     <= req_b[win_idx*WIDTH +: WIDTH];
            lu_op    <= req_op[win_idx*LU_OP_W +: LU_OP_W];
            gnt      <= win;
            lu_start <= 1'b1;
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          if (lu_finish) begin
            result <= lu_c;
            err    <= 1'b0;
            done   <= NREQ'(1) << w_idx;
          end else if (timed_out) begin
            result <= '0;
            err    <= 1'b1;
            done   <= NREQ'(1) << w_idx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: ptr <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_sched.sv
// Self-checking bench for logic_op_sched: opcode table, directed multi-cycle cases,
// and randomized traffic against a round-robin reference model.
module tb_logic_op_sched;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ-1:0]       gnt, done;
  logic [WIDTH-1:0]      result, lu_a, lu_b, lu_c;
  logic                  err, busy, lu_start, lu_finish;
  logic [2:0]            lu_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_op_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .lu_start(lu_start), .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op),
    .lu_finish(lu_finish), .lu_c(lu_c)
  );

  function automatic logic [WIDTH-1:0] lop(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
    case (op)
      3'd0: return ~a;
      3'd1: return ~b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // Logic unit model: finish goes high unit_delay cycles into WAIT, never if never_finish.
  int   unit_delay = 0;
  logic never_finish = 1'b0;
  logic armed;
  int   lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      lat   <= 0;
    end else if (lu_start) begin
      armed <= 1'b1;
      lat   <= 0;
    end else if (armed) begin
      if (lu_finish) armed <= 1'b0;
      lat <= lat + 1;
    end
  end

  assign lu_finish = armed && !never_finish && (lat == unit_delay);
  assign lu_c      = lop(lu_op, lu_a, lu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_lu_start"}, lu_start, 0);
    chk({tag, "_lu_a"}, lu_a, 0);
    chk({tag, "_lu_b"}, lu_b, 0);
    chk({tag, "_lu_op"}, lu_op, 0);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, b, input logic [2:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*3 +: 3]        = op;
    req[i]                  = 1'b1;
  endtask

  // One request from an idle scheduler; t counts negedges after req is raised.
  task automatic single_op(input string name, input int i, input logic [WIDTH-1:0] a, b,
                           input logic [2:0] op, input logic [WIDTH-1:0] exp_res,
                           input logic exp_err, input int exp_done_t);
    int t;
    bit seen;
    @(negedge clk);
    set_req(i, a, b, op);
    seen = 0;
    for (t = 1; t <= 40 && !seen; t++) begin
      @(negedge clk);
      if (gnt != 0) begin
        seen = 1;
        chk({name, "_gnt"}, gnt, 64'(1) << i);
        chk({name, "_gnt_cycle"}, t, 1);
        chk({name, "_lu_start"}, lu_start, 1);
        chk({name, "_lu_ops"}, {lu_op, lu_a, lu_b}, {op, a, b});
        req[i] = 1'b0;
      end
    end
    if (!seen) chk({name, "_gnt_timeout"}, 0, 1);
    seen = 0;
    for (; t <= 60 && !seen; t++) begin
      if (t > 2) @(negedge clk);
      else @(negedge clk);
      if (done != 0) begin
        seen = 1;
        chk({name, "_done"}, done, 64'(1) << i);
        chk({name, "_done_cycle"}, t, exp_done_t);
        chk({name, "_result"}, result, exp_res);
        chk({name, "_err"}, err, exp_err);
      end
    end
    if (!seen) chk({name, "_done_timeout"}, 0, 1);
  endtask

  // Several requests raised together; grants expected in ord[] at cycles 1,5,9,..
  task automatic run_batch(input string name, input logic [NREQ-1:0] mask,
                           input int ord[NREQ], input int n);
    logic [WIDTH-1:0] ea[NREQ];
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    int g = 0;
    int d = 0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      ea[i] = '0;
      if (mask[i]) begin
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        ea[i] = lop(op, a, b);
        set_req(i, a, b, op);
      end
    end
    for (int t = 1; t <= 4*n + 4; t++) begin
      @(negedge clk);
      if (gnt != 0) begin
        if (g < n) begin
          chk({name, "_gnt_order"}, gnt, 64'(1) << ord[g]);
          chk({name, "_gnt_cycle"}, t, 1 + 4*g);
        end
        req = req & ~gnt;
        g++;
      end
      if (done != 0) begin
        if (d < n) begin
          chk({name, "_done_order"}, done, 64'(1) << ord[d]);
          chk({name, "_done_cycle"}, t, 3 + 4*d);
          chk({name, "_result"}, result, ea[ord[d]]);
        end
        d++;
      end
    end
    chk({name, "_n_gnt"}, g, n);
    chk({name, "_n_done"}, d, n);
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int ord[NREQ];
    int rptr, inflight, ops, w;
    logic [NREQ-1:0]  req_prev;
    logic [WIDTH-1:0] exp_res;
    int wait_ops[NREQ];
    logic [63:0] exp_done;
    bit done_seen;

    req = '0; req_a = '0; req_b = '0; req_op = '0;
    do_reset();

    tbl[0] = '{3'd2, 32'hF0F0_0000, 32'h0FF0_0000, 32'h00F0_0000};
    tbl[1] = '{3'd0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_AAAA};
    tbl[2] = '{3'd1, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0000_FFFF};
    tbl[3] = '{3'd2, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000};
    tbl[4] = '{3'd3, 32'hAAAA_5555, 32'hFFFF_0000, 32'hFFFF_5555};
    tbl[5] = '{3'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    tbl[6] = '{3'd5, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_FFFF};
    tbl[7] = '{3'd6, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0000_AAAA};
    tbl[8] = '{3'd7, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_AAAA};

    // First entry is the single-request case on requester 2; the rest sweep opcodes.
    for (int k = 0; k < 9; k++)
      single_op($sformatf("tbl%0d", k), (k == 0) ? 2 : k % NREQ,
                tbl[k].a, tbl[k].b, tbl[k].op, tbl[k].exp, 1'b0, 3);

    unit_delay = 3;
    single_op("slow_unit", 1, 32'h1234_5678, 32'h0F0F_0F0F, 3'd4, 32'h1D3B_5977, 1'b0, 6);
    unit_delay = 0;

    do_reset();
    ord = '{0, 1, 2, 3};
    run_batch("all4", 4'hF, ord, 4);

    do_reset();
    single_op("ptr_setup", 1, 32'h0000_00FF, 32'h0000_0F0F, 3'd3, 32'h0000_0FFF, 1'b0, 3);
    ord = '{3, 0, 0, 0};
    run_batch("ptr2", 4'b1001, ord, 2);

    never_finish = 1'b1;
    single_op("timeout", 1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'd2, 32'h0, 1'b1, TIMEOUT + 3);
    never_finish = 1'b0;
    single_op("after_to", 3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'd2, 32'hDEAD_BEEF, 1'b0, 3);

    // Reset while the unit is still working; ptr was 0 only by coincidence, so make it 2 first.
    single_op("pre_abort", 1, 32'h1, 32'h2, 3'd3, 32'h3, 1'b0, 3);
    unit_delay = 10;
    @(negedge clk);
    set_req(2, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 3'd4);
    @(negedge clk);
    chk("abort_gnt", gnt, 4'b0100);
    req[2] = 1'b0;
    @(negedge clk);
    chk("abort_busy_in_wait", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    unit_delay = 0;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done != 0) done_seen = 1;
    end
    chk("abort_no_done", done_seen, 0);
    ord = '{0, 2, 0, 0};
    run_batch("post_abort", 4'b0101, ord, 2);

    // Randomized traffic against a round-robin reference model.
    do_reset();
    rptr = 0; inflight = -1; ops = 0; req_prev = '0; exp_res = '0;
    for (int i = 0; i < NREQ; i++) wait_ops[i] = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (gnt != 0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_prev[(rptr + k) % NREQ]) w = (rptr + k) % NREQ;
        chk("rnd_gnt", gnt, (w >= 0) ? (64'(1) << w) : 64'(0));
        if (w >= 0) begin
          chk("rnd_no_starve", wait_ops[w] < NREQ, 1);
          for (int j = 0; j < NREQ; j++) if (req_prev[j] && j != w) wait_ops[j]++;
          wait_ops[w] = 0;
          inflight = w;
          exp_res = lop(req_op[w*3 +: 3], req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH]);
          req[w] = 1'b0;
          unit_delay = $urandom_range(0, 4);
        end
      end
      if (done != 0) begin
        exp_done = (inflight >= 0) ? (64'(1) << inflight) : 64'(0);
        chk("rnd_done", done, exp_done);
        chk("rnd_result", result, exp_res);
        chk("rnd_err", err, 0);
        if (inflight >= 0) rptr = (inflight + 1) % NREQ;
        inflight = -1;
        ops++;
      end
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && inflight != i && $urandom_range(0, 3) == 0) begin
          set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
          wait_ops[i] = 0;
        end
      req_prev = req;
    end
    chk("rnd_progress", ops >= 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
